// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle integer ALU between N_REQ requesters.
// Three-state FSM (Idle -> Issue -> Resp) grants one request at a time,
// registers its operands, drives the external ALU for one cycle and returns
// the registered result on the granted port's response channel.
module alu_arbiter #(
   parameter int unsigned N_REQ      = 2,
   parameter bit          PRIO_FIXED = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [32*N_REQ-1:0]  req_data1,
   input  logic [32*N_REQ-1:0]  req_data2,
   input  logic [4*N_REQ-1:0]   req_aluop,
   output logic [N_REQ-1:0]     rsp_valid,
   input  logic [N_REQ-1:0]     rsp_ready,
   output logic [31:0]          rsp_result,
   output logic                 rsp_zero,
   output logic                 rsp_err,
   output logic [31:0]          alu_data1,
   output logic [31:0]          alu_data2,
   output logic [3:0]           alu_aluop,
   input  logic [31:0]          alu_result,
   input  logic                 alu_zero,
   output logic                 busy
);

   // Index width for N_REQ in 2..4.
   localparam int unsigned IdxW = (N_REQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StResp  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   grant_q;
   logic [31:0]       data1_q, data2_q;
   logic [3:0]        op_q;
   logic [31:0]       result_q;
   logic              zero_q;
   logic              err_q;

   logic [IdxW-1:0]   win_idx;
   logic              win_found;
   logic              req_hs;
   logic              rsp_hs;
   int unsigned       cand;
   logic [IdxW-1:0]   cand_idx;

   // Arbitration: round-robin search from ptr, or lowest index first.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (PRIO_FIXED) begin
            cand = k;
         end else begin
            cand = (32'(ptr_q) + k) % N_REQ;
         end
         cand_idx = IdxW'(cand);
         if (!win_found && req_valid[cand_idx]) begin
            win_idx   = cand_idx;
            win_found = 1'b1;
         end
      end
   end

   // The winner is by construction valid, so ready for it means handshake.
   assign req_hs = (state_q == StIdle) && win_found;
   // Only the granted port's rsp_ready completes a response.
   assign rsp_hs = (state_q == StResp) && rsp_ready[grant_q];

   // Next-state and FSM-decoded outputs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      req_ready = '0;
      rsp_valid = '0;
      alu_data1 = '0;
      alu_data2 = '0;
      alu_aluop = '0;
      busy      = 1'b1;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (win_found) begin
               req_ready[win_idx] = 1'b1;
               state_d            = StIssue;
            end
         end
         StIssue: begin
            alu_data1 = data1_q;
            alu_data2 = data2_q;
            alu_aluop = op_q;
            state_d   = StResp;
         end
         StResp: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_hs) begin
               state_d = StIdle;
               if (32'(grant_q) == N_REQ - 1) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = grant_q + IdxW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM state and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Operand and grant capture on request handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data1_q <= '0;
         data2_q <= '0;
         op_q    <= '0;
         grant_q <= '0;
      end else if (req_hs) begin
         data1_q <= req_data1[32*win_idx +: 32];
         data2_q <= req_data2[32*win_idx +: 32];
         op_q    <= req_aluop[4*win_idx +: 4];
         grant_q <= win_idx;
      end
   end

   // Result capture at the end of Issue; held stable through Resp.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (state_q == StIssue) begin
         err_q <= op_q[3];
         if (op_q[3]) begin
            // Illegal op: ignore whatever the ALU produced.
            result_q <= '0;
            zero_q   <= 1'b1;
         end else begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
         end
      end
   end

   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer ALU between N_REQ requesters, e.g. the execute stage and an address-generation or CSR unit, so only one ALU instance is needed. Each requester has a valid/ready request channel and a valid/ready response channel. A three-state FSM grants one request at a time, by round-robin or fixed priority. It registers the operands, drives the ALU for one cycle, and returns the registered result to the granted requester.

## Interface
- N_REQ, 2, number of requesters (legal 2..4)
- PRIO_FIXED, 0, 0 = round-robin; 1 = fixed priority, lowest index wins

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-port request valid
- req_ready  out  N_REQ  per-port request accept
- req_data1  in  32*N_REQ  operand 1, port i at bits [32i+31:32i]
- req_data2  in  32*N_REQ  operand 2, same packing
- req_aluop  in  4*N_REQ  ALU op, port i at bits [4i+3:4i]
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_ready  in  N_REQ  per-port response accept
- rsp_result  out  32  result, shared by all ports
- rsp_zero  out  1  zero flag of the result
- rsp_err  out  1  illegal aluop (aluop[3]=1)
- alu_data1  out  32  to ALU data1
- alu_data2  out  32  to ALU data2
- alu_aluop  out  4  to ALU aluop
- alu_result  in  32  from ALU (combinational)
- alu_zero  in  1  from ALU
- busy  out  1  FSM not in IDLE

## Operation
- ALU op encoding: AND=0, OR=1, ADD=2, SUB=3, XOR=4, SLL=5, SRL=6, SLT=7. Codes 8..15 are illegal.
- FSM states and transitions:
  - IDLE:
    - Arbitrate over req_valid.
    - req_ready is asserted combinationally for the winner only.
    - On handshake, capture data1, data2, aluop and the grant index. Go to ISSUE.
    - No valid request: stay in IDLE.
  - ISSUE:
    - alu_* are driven from the captured registers.
    - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero. Set rsp_err = op[3].
    - If op[3]=1: force rsp_result=0 and rsp_zero=1. Go to RESP.
  - RESP:
    - rsp_valid[grant]=1. rsp_result, rsp_zero and rsp_err stay stable until handshake.
    - On rsp_ready[grant]: go to IDLE and update the arbitration pointer.
    - No new request is accepted in RESP.
- Arbitration:
  - Round-robin: search starts at ptr and wraps modulo N_REQ. After each completed response, ptr = grant+1 mod N_REQ.
  - Fixed priority: the lowest asserted index wins and ptr is unused.
- req_ready is 0 outside IDLE.
- rsp_ready on non-granted ports is ignored.
- alu_* outputs are 0 when the FSM is not in ISSUE, to hold ALU inputs quiet.
- req_valid may drop without a handshake. Arbitration re-evaluates every IDLE cycle; there is no lock before handshake.

## Timing
- Reset (async assert, sync release):
  - FSM=IDLE, ptr=0.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - alu_*=0, busy=0.
  - req_ready follows req_valid arbitration immediately after release.
- Reset mid-transaction drops the transaction with no response. The requester must reissue.
- Latency and throughput:
  - Request handshake at edge T, then ISSUE during cycle T+1, then rsp_valid high in cycle T+2.
  - With rsp_ready held high, the next accept is possible in cycle T+3. Throughput is 1 op per 3 cycles.
- Backpressure: rsp_valid stays high and outputs stay frozen indefinitely while rsp_ready is low.
- Width rules:
  - 32-bit wraparound on ADD/SUB.
  - Shift amount is data2[4:0].
  - SLT is signed.
- A request arriving on a port during RESP waits; it is not lost as long as the requester holds valid.

## Test plan
- Single op: port0 ADD 5,7 at T -> alu_aluop=2, alu_data1=5, alu_data2=7 in T+1; rsp_valid=01, rsp_result=12, rsp_zero=0 at T+2.
- Contention, round-robin, both ports valid continuously:
  - port0 SUB 9,9 and port1 OR 0xF0,0x0F.
  - Grant order is 0,1,0,1. Port0 responses: result 0, zero=1. Port1 responses: result 0xFF.
  - With PRIO_FIXED=1, only port0 is granted.
- Backpressure: port1 SLT 0xFFFFFFFF,1 with rsp_ready low for 5 cycles:
  - rsp_valid=10 and rsp_result=1 stable throughout; req_ready=00 and busy=1.
  - On release, back to IDLE the next cycle.
- Illegal op: port0 aluop=4'b1010 -> rsp_err=1, rsp_result=0, rsp_zero=1. The next legal ADD clears rsp_err.
- Shift and wrap:
  - SLL 1,33 -> 2.
  - ADD 0xFFFFFFFF,1 -> 0 with zero=1.
  - SRL 0x80000000,31 -> 1.
- Reset mid-op: assert rst during ISSUE -> all outputs 0 the same cycle, no rsp_valid afterwards, ptr=0. A reissued request completes normally.
